// File: rtl/packet_gen_sched.sv
// packet_gen_sched: queues job descriptors and launches them one at a time on an external packet generator.
// Define PACKET_GEN_SCHED_TIMER_EN to measure each job's duration on last_job_cycles.
module packet_gen_sched #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [79:0]                job_data,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic                       run,
  input  logic                       abort,
  output logic [31:0]                gen_packet_count,
  output logic [15:0]                gen_packet_length,
  output logic [15:0]                gen_idle_cycles,
  output logic [15:0]                gen_initial_value,
  output logic                       gen_start,
  input  logic                       gen_busy,
  output logic [$clog2(DEPTH):0]     queue_count,
  output logic [31:0]                jobs_done,
  output logic                       idle,
  output logic [31:0]                last_job_cycles
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, RUNNING} state_e;

  state_e        state_q;
  logic [79:0]   mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q;
  logic [PW-1:0] rdPtr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [79:0]   head;
  logic          push;
  logic          pop;
  logic          launch;
  logic [31:0]   genCount_q;
  logic [15:0]   genLength_q;
  logic [15:0]   genIdle_q;
  logic [15:0]   genInit_q;
  logic          genStart_q;
  logic [31:0]   jobsDone_q;

  assign head      = mem_q[rdPtr_q];
  assign job_ready = resetn && (count_q < CW'(DEPTH));
  // abort wins over both queue operations: the flush discards everything, including a same-cycle push or pop.
  assign push      = job_valid && job_ready && !abort;
  assign pop       = (state_q == IDLE) && run && (count_q != '0) && !abort;
  assign launch    = pop && (head[31:0] != '0) && (head[47:32] != '0);

  always_comb begin
    count_d = count_q;
    if (abort) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (abort) begin
        wrPtr_q <= '0;
        rdPtr_q <= '0;
      end else begin
        if (push) wrPtr_q <= wrPtr_q + PW'(1);
        if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= job_data;
  end

  // Descriptors with a zero count or length are popped and dropped without ever reaching the generator.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      genStart_q  <= 1'b0;
      genCount_q  <= '0;
      genLength_q <= '0;
      genIdle_q   <= '0;
      genInit_q   <= '0;
      jobsDone_q  <= '0;
    end else begin
      genStart_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (launch) begin
            genCount_q  <= head[31:0];
            genLength_q <= head[47:32];
            genIdle_q   <= head[63:48];
            genInit_q   <= head[79:64];
            genStart_q  <= 1'b1;
            state_q     <= LAUNCH;
          end
        end
        LAUNCH: state_q <= RUNNING;
        RUNNING: begin
          if (!gen_busy) begin
            jobsDone_q <= jobsDone_q + 32'd1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PACKET_GEN_SCHED_TIMER_EN
  logic [31:0] timer_q;
  logic [31:0] timerInc;
  logic [31:0] lastCycles_q;

  assign timerInc = (timer_q == '1) ? timer_q : timer_q + 32'd1;

  // The latched duration includes the completing cycle, hence timerInc rather than timer_q.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q      <= '0;
      lastCycles_q <= '0;
    end else begin
      if (launch) begin
        timer_q <= '0;
      end else if (state_q != IDLE) begin
        timer_q <= timerInc;
      end
      if ((state_q == RUNNING) && !gen_busy) lastCycles_q <= timerInc;
    end
  end

  assign last_job_cycles = lastCycles_q;
`else
  assign last_job_cycles = '0;
`endif

  assign gen_packet_count  = genCount_q;
  assign gen_packet_length = genLength_q;
  assign gen_idle_cycles   = genIdle_q;
  assign gen_initial_value = genInit_q;
  assign gen_start         = genStart_q;
  assign queue_count       = count_q;
  assign jobs_done         = jobsDone_q;
  assign idle              = (state_q == IDLE) && (count_q == '0);

endmodule

// File: tb/tb_packet_gen_sched.sv
// tb_packet_gen_sched: directed scenarios plus random traffic against a cycle-numbered reference model.
// Honours PACKET_GEN_SCHED_TIMER_EN when predicting last_job_cycles.
module tb_packet_gen_sched;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic [79:0]   job_data;
  logic          job_valid;
  logic          job_ready;
  logic          run;
  logic          abort;
  logic [31:0]   gen_packet_count;
  logic [15:0]   gen_packet_length;
  logic [15:0]   gen_idle_cycles;
  logic [15:0]   gen_initial_value;
  logic          gen_start;
  logic          gen_busy;
  logic [CW-1:0] queue_count;
  logic [31:0]   jobs_done;
  logic          idle;
  logic [31:0]   last_job_cycles;

  always #5 clk = ~clk;

  packet_gen_sched #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .job_data          (job_data),
    .job_valid         (job_valid),
    .job_ready         (job_ready),
    .run               (run),
    .abort             (abort),
    .gen_packet_count  (gen_packet_count),
    .gen_packet_length (gen_packet_length),
    .gen_idle_cycles   (gen_idle_cycles),
    .gen_initial_value (gen_initial_value),
    .gen_start         (gen_start),
    .gen_busy          (gen_busy),
    .queue_count       (queue_count),
    .jobs_done         (jobs_done),
    .idle              (idle),
    .last_job_cycles   (last_job_cycles)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int startsSeen = 0;

  // Reference model: the queue contents, whether a job is in flight, and the cycle its start pulse belongs to.
  logic [79:0] mQ[$];
  bit          mInJob;
  int          mStart;
  logic [31:0] mDone;
  logic [31:0] mLast;
  logic [79:0] mCfg;
  int          busyLeft;
  bit          randomBusy;
  int          fixedBusy;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    mInJob   = 1'b0;
    mStart   = 0;
    mDone    = '0;
    mLast    = '0;
    mCfg     = '0;
    busyLeft = 0;
  endtask

  task automatic compareAll();
    logic [31:0] expLast;
`ifdef PACKET_GEN_SCHED_TIMER_EN
    expLast = mLast;
`else
    expLast = '0;
`endif
    checkOutput("gen_start", 64'(gen_start), 64'(mInJob && (cyc == mStart)));
    checkOutput("job_ready", 64'(job_ready), 64'(mQ.size() < DEPTH));
    checkOutput("queue_count", 64'(queue_count), 64'(mQ.size()));
    checkOutput("idle", 64'(idle), 64'(!mInJob && (mQ.size() == 0)));
    checkOutput("jobs_done", 64'(jobs_done), 64'(mDone));
    checkOutput("gen_packet_count", 64'(gen_packet_count), 64'(mCfg[31:0]));
    checkOutput("gen_packet_length", 64'(gen_packet_length), 64'(mCfg[47:32]));
    checkOutput("gen_idle_cycles", 64'(gen_idle_cycles), 64'(mCfg[63:48]));
    checkOutput("gen_initial_value", 64'(gen_initial_value), 64'(mCfg[79:64]));
    checkOutput("last_job_cycles", 64'(last_job_cycles), 64'(expLast));
  endtask

  // A job ends on the first cycle after its start with the generator idle; only a free scheduler pops.
  task automatic modelStep();
    bit          ready;
    logic [79:0] d;
    ready = (mQ.size() < DEPTH);
    if (mInJob) begin
      if ((cyc > mStart) && !gen_busy) begin
        mDone++;
        mLast  = 32'(cyc - mStart + 1);
        mInJob = 1'b0;
      end
    end else if (run && !abort && (mQ.size() > 0)) begin
      d = mQ.pop_front();
      if ((d[31:0] != 0) && (d[47:32] != 0)) begin
        mCfg   = d;
        mInJob = 1'b1;
        mStart = cyc + 1;
      end
    end
    if (job_valid && ready && !abort) mQ.push_back(job_data);
    if (abort) mQ.delete();
  endtask

  task automatic applyStimulus(input bit v, input logic [79:0] d, input bit r, input bit a);
    @(posedge clk);
    #1;
    cyc++;
    resetn    = 1'b1;
    job_valid = v;
    job_data  = d;
    run       = r;
    abort     = a;
    if (mInJob && (cyc == mStart)) busyLeft = randomBusy ? int'($urandom_range(1, 12)) : fixedBusy;
    gen_busy = (busyLeft > 0);
    if (busyLeft > 0) busyLeft--;
    @(negedge clk);
    if (gen_start === 1'b1) startsSeen++;
    compareAll();
    modelStep();
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((idle === 1'b1) && !mInJob && (mQ.size() == 0)) break;
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
    end
    checkOutput("drain_idle", 64'(idle), 64'(1));
  endtask

  task automatic waitRunning(input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (mInJob && (cyc > mStart)) begin
        found = 1'b1;
        break;
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
    end
    checkOutput("reach_running", 64'(found), 64'(1));
  endtask

  task automatic checkResetValues();
    checkOutput("rst_gen_start", 64'(gen_start), 64'(0));
    checkOutput("rst_job_ready", 64'(job_ready), 64'(0));
    checkOutput("rst_queue_count", 64'(queue_count), 64'(0));
    checkOutput("rst_idle", 64'(idle), 64'(1));
    checkOutput("rst_jobs_done", 64'(jobs_done), 64'(0));
    checkOutput("rst_gen_cfg", 64'({gen_packet_length, gen_idle_cycles, gen_initial_value}), 64'(0));
    checkOutput("rst_gen_count", 64'(gen_packet_count), 64'(0));
    checkOutput("rst_last_cycles", 64'(last_job_cycles), 64'(0));
  endtask

  function automatic logic [79:0] mkJob(input int i);
    return {16'(i + 1), 16'd1, 16'(8 + i), 32'(1 + i)};
  endfunction

  initial begin
    int          s0;
    logic [31:0] expLast;
    resetn    = 1'b0;
    job_valid = 1'b0;
    job_data  = '0;
    run       = 1'b0;
    abort     = 1'b0;
    gen_busy  = 1'b0;
    randomBusy = 1'b0;
    fixedBusy  = 10;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkResetValues();

    // Single job: start two cycles after acceptance, ten busy cycles give an eleven-cycle job.
`ifdef PACKET_GEN_SCHED_TIMER_EN
    expLast = 32'd11;
`else
    expLast = 32'd0;
`endif
    applyStimulus(1'b1, {16'h0010, 16'd2, 16'd64, 32'd3}, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("latency_t2", 64'(gen_start), 64'(1));
    checkOutput("first_cfg_count", 64'(gen_packet_count), 64'(3));
    checkOutput("first_cfg_len", 64'(gen_packet_length), 64'(64));
    waitDrain(100);
    checkOutput("first_jobs_done", 64'(jobs_done), 64'(1));
    checkOutput("first_duration", 64'(last_job_cycles), 64'(expLast));

    // Overfill while stopped, then release.
    randomBusy = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, mkJob(i), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("full_count", 64'(queue_count), 64'(4));
    checkOutput("full_ready", 64'(job_ready), 64'(0));
    s0 = startsSeen;
    waitDrain(200);
    checkOutput("full_starts", 64'(startsSeen - s0), 64'(4));
    checkOutput("full_jobs_done", 64'(jobs_done), 64'(5));

    // Zero count and zero length descriptors are dropped.
    s0 = startsSeen;
    applyStimulus(1'b1, {16'h1, 16'h2, 16'd5, 32'd0}, 1'b1, 1'b0);
    applyStimulus(1'b1, {16'h3, 16'h4, 16'd0, 32'd7}, 1'b1, 1'b0);
    applyStimulus(1'b1, {16'hBEEF, 16'h5, 16'd9, 32'd11}, 1'b1, 1'b0);
    waitDrain(100);
    checkOutput("skip_starts", 64'(startsSeen - s0), 64'(1));
    checkOutput("skip_cfg_count", 64'(gen_packet_count), 64'(11));
    checkOutput("skip_cfg_init", 64'(gen_initial_value), 64'(16'hBEEF));
    checkOutput("skip_jobs_done", 64'(jobs_done), 64'(6));

    // Abort while the first of three jobs is running.
    randomBusy = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, mkJob(i + 10), 1'b0, 1'b0);
    s0 = startsSeen;
    waitRunning(20);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    waitDrain(100);
    checkOutput("abort_starts", 64'(startsSeen - s0), 64'(1));
    checkOutput("abort_count", 64'(queue_count), 64'(0));
    checkOutput("abort_jobs_done", 64'(jobs_done), 64'(7));

    // Random traffic.
    randomBusy = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(1'($urandom_range(0, 1)),
                    {16'($urandom), 16'($urandom_range(0, 5)), 16'($urandom_range(0, 3)), 32'($urandom_range(0, 3))},
                    ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0));
    end
    waitDrain(200);

    // Reset in the middle of a running job.
    randomBusy = 1'b0;
    applyStimulus(1'b1, mkJob(20), 1'b1, 1'b0);
    waitRunning(20);
    resetn = 1'b0;
    #1;
    checkResetValues();
    modelReset();
    gen_busy = 1'b0;
    applyStimulus(1'b1, mkJob(21), 1'b1, 1'b0);
    waitDrain(100);
    checkOutput("post_reset_jobs_done", 64'(jobs_done), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
